// File: rtl/instruction_fetch.sv
// -----------------------------------------------------------------------------
// instruction_fetch
//
// Front end of the MIPS pipeline. Owns the program counter, drives the
// synchronous instruction ROM and hands one instruction per cycle to decode.
// A one-entry hold buffer keeps the instruction steady while decode stalls.
// Branch redirects keep the delay slot, and a flush restarts fetch at the
// exception/eret target.
//
// Ports
//   clock              system clock, rising edge
//   reset              asynchronous, active-high reset
//   rom_address  [31:0] fetch address (always the PC register)
//   rom_enable         ROM sample enable (~reset & ~stall)
//   rom_data     [31:0] ROM read data, valid the cycle after an enabled edge
//   stall              decode cannot accept the current instruction
//   branch             decode resolved a taken branch/jump
//   branch_address[31:0] branch/jump target
//   flush              exception/eret redirect
//   flush_address[31:0] redirect target
//   instruction  [31:0] instruction presented to decode
//   instruction_pc[31:0] address of instruction
//   instruction_valid  instruction is real (0 = bubble)
// -----------------------------------------------------------------------------
module instruction_fetch #(
  parameter logic [31:0] RESET_ADDRESS = 32'h00000000
) (
  input  logic        clock,
  input  logic        reset,
  output logic [31:0] rom_address,
  output logic        rom_enable,
  input  logic [31:0] rom_data,
  input  logic        stall,
  input  logic        branch,
  input  logic [31:0] branch_address,
  input  logic        flush,
  input  logic [31:0] flush_address,
  output logic [31:0] instruction,
  output logic [31:0] instruction_pc,
  output logic        instruction_valid
);

  logic [31:0] pc_reg;
  logic        fetch_valid_reg;
  logic [31:0] fetch_pc_reg;
  logic        hold_valid_reg;
  logic [31:0] hold_instruction_reg;
  logic [31:0] hold_pc_reg;

  // Word alignment of redirect targets.
  localparam logic [31:0] WORD_MASK = ~32'h00000003;

  assign rom_address = pc_reg;
  // The ROM must not sample while stalled: pc is held and the instruction
  // already fetched lives in the hold buffer (or is still on rom_data).
  assign rom_enable  = ~reset & ~stall;

  // The hold buffer takes precedence; otherwise the ROM output is live.
  always_comb begin
    if (hold_valid_reg) begin
      instruction       = hold_instruction_reg;
      instruction_pc    = hold_pc_reg;
      instruction_valid = 1'b1;
    end else begin
      instruction       = rom_data;
      instruction_pc    = fetch_pc_reg;
      instruction_valid = fetch_valid_reg;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc_reg               <= RESET_ADDRESS;
      fetch_valid_reg      <= 1'b0;
      fetch_pc_reg         <= 32'h0;
      hold_valid_reg       <= 1'b0;
      hold_instruction_reg <= 32'h0;
      hold_pc_reg          <= 32'h0;
    end else if (flush) begin
      // Flush beats stall and branch; the held instruction is discarded.
      pc_reg          <= flush_address & WORD_MASK;
      fetch_valid_reg <= 1'b0;
      hold_valid_reg  <= 1'b0;
    end else if (stall) begin
      // rom_data is only valid for one cycle, so capture it now if it is
      // the instruction decode is looking at. Branch is ignored here; decode
      // reasserts it on the cycle the stall clears.
      if (!hold_valid_reg && fetch_valid_reg) begin
        hold_valid_reg       <= 1'b1;
        hold_instruction_reg <= rom_data;
        hold_pc_reg          <= fetch_pc_reg;
      end
      fetch_valid_reg <= 1'b0;
    end else begin
      // The ROM samples pc on this edge. When a branch is seen, pc already
      // points at the delay slot, so the slot is fetched before the target.
      fetch_pc_reg    <= pc_reg;
      fetch_valid_reg <= 1'b1;
      hold_valid_reg  <= 1'b0;
      if (branch && instruction_valid) begin
        pc_reg <= branch_address & WORD_MASK;
      end else begin
        pc_reg <= pc_reg + 32'd4;
      end
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// -----------------------------------------------------------------------------
// tb_instruction_fetch
//
// Directed bench for instruction_fetch. A behavioural synchronous ROM returns
// {16'h3401, word_index} for enabled reads and a garbage word otherwise.
// Stimulus pushes the expected (pc, instruction) stream into a queue; a
// forked monitor pops one entry for every cycle the DUT shows a valid
// instruction. Bubbles and reset behaviour are checked directly.
// -----------------------------------------------------------------------------
module tb_instruction_fetch;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] rom_address;
  logic        rom_enable;
  logic [31:0] rom_data = 32'h0;
  logic        stall = 1'b0;
  logic        branch = 1'b0;
  logic [31:0] branch_address = 32'h0;
  logic        flush = 1'b0;
  logic [31:0] flush_address = 32'h0;
  logic [31:0] instruction;
  logic [31:0] instruction_pc;
  logic        instruction_valid;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  instruction_fetch #(.RESET_ADDRESS(32'h00000000)) dut (
    .clock            (clock),
    .reset            (reset),
    .rom_address      (rom_address),
    .rom_enable       (rom_enable),
    .rom_data         (rom_data),
    .stall            (stall),
    .branch           (branch),
    .branch_address   (branch_address),
    .flush            (flush),
    .flush_address    (flush_address),
    .instruction      (instruction),
    .instruction_pc   (instruction_pc),
    .instruction_valid(instruction_valid)
  );

  always #5 clock = ~clock;

  // Synchronous ROM: data is only meaningful after an enabled edge.
  always @(posedge clock) begin
    if (rom_enable) rom_data <= {16'h3401, rom_address[17:2]};
    else            rom_data <= 32'hDEADBEEF;
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic expect_insn(input logic [31:0] pc, input logic [31:0] data);
    exp_t e;
    e.pc   = pc;
    e.data = data;
    exp_q.push_back(e);
  endtask

  // Apply inputs for one cycle; returns 1 time unit after the next edge.
  task automatic step(input logic s, input logic b, input logic [31:0] ba,
                      input logic f, input logic [31:0] fa);
    stall          = s;
    branch         = b;
    branch_address = ba;
    flush          = f;
    flush_address  = fa;
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic do_reset(input int n);
    reset          = 1'b1;
    stall          = 1'b0;
    branch         = 1'b0;
    branch_address = 32'h0;
    flush          = 1'b0;
    flush_address  = 32'h0;
    @(posedge clock);
    #1;
    check("reset valid", {31'h0, instruction_valid}, 32'h0);
    check("reset pc", instruction_pc, 32'h0);
    check("reset rom_enable", {31'h0, rom_enable}, 32'h0);
    check("reset rom_address", rom_address, 32'h0);
    repeat (n - 1) @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  task automatic end_test(input string name);
    check({name, " drained"}, exp_q.size(), 32'h0);
    exp_q.delete();
  endtask

  initial begin
    fork
      forever begin
        @(negedge clock);
        if (!reset && instruction_valid) begin
          if (exp_q.size() == 0) begin
            check("unexpected instruction pc", instruction_pc, 32'hFFFFFFFF);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("instruction_pc", instruction_pc, e.pc);
            check("instruction", instruction, e.data);
            $display("txn pc=%h insn=%h (want pc=%h insn=%h)",
                     instruction_pc, instruction, e.pc, e.data);
          end
        end
      end
    join_none

    // Reset and straight-line sequence
    do_reset(10);
    expect_insn(32'h0, 32'h34010000);
    expect_insn(32'h4, 32'h34010001);
    expect_insn(32'h8, 32'h34010002);
    expect_insn(32'hC, 32'h34010003);
    check("first cycle bubble", {31'h0, instruction_valid}, 32'h0);
    idle(5);
    end_test("sequence");

    // Stall hold while pc 8 is shown
    do_reset(2);
    expect_insn(32'h0, 32'h34010000);
    expect_insn(32'h4, 32'h34010001);
    repeat (4) expect_insn(32'h8, 32'h34010002);
    expect_insn(32'hC, 32'h34010003);
    idle(3);
    step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    check("stall rom_enable", {31'h0, rom_enable}, 32'h0);
    step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    idle(2);
    end_test("stall");

    // Branch with delay slot
    do_reset(2);
    expect_insn(32'h0,  32'h34010000);
    expect_insn(32'h4,  32'h34010001);
    expect_insn(32'h8,  32'h34010002);
    expect_insn(32'h40, 32'h34010010);
    expect_insn(32'h44, 32'h34010011);
    idle(2);
    step(1'b0, 1'b1, 32'h40, 1'b0, 32'h0);
    idle(3);
    end_test("branch");

    // Branch under stall: redirect only on the non-stalled edge
    do_reset(2);
    expect_insn(32'h0,  32'h34010000);
    repeat (3) expect_insn(32'h4, 32'h34010001);
    expect_insn(32'h8,  32'h34010002);
    expect_insn(32'h80, 32'h34010020);
    idle(2);
    step(1'b1, 1'b1, 32'h82, 1'b0, 32'h0);
    step(1'b1, 1'b1, 32'h82, 1'b0, 32'h0);
    step(1'b0, 1'b1, 32'h82, 1'b0, 32'h0);
    idle(2);
    end_test("branch under stall");

    // Flush beats stall, branch and a pending hold
    do_reset(2);
    expect_insn(32'h0,   32'h34010000);
    expect_insn(32'h4,   32'h34010001);
    expect_insn(32'h4,   32'h34010001);
    expect_insn(32'h180, 32'h34010060);
    expect_insn(32'h184, 32'h34010061);
    idle(2);
    step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    step(1'b1, 1'b1, 32'h40, 1'b1, 32'h181);
    check("flush bubble", {31'h0, instruction_valid}, 32'h0);
    check("flush rom_address", rom_address, 32'h180);
    idle(3);
    end_test("flush");

    // Wrap past the top of memory, then asynchronous reset mid-stall
    do_reset(2);
    expect_insn(32'h0,        32'h34010000);
    expect_insn(32'h4,        32'h34010001);
    expect_insn(32'hFFFFFFFC, 32'h3401FFFF);
    expect_insn(32'h0,        32'h34010000);
    expect_insn(32'h4,        32'h34010001);
    idle(1);
    step(1'b0, 1'b1, 32'hFFFFFFFC, 1'b0, 32'h0);
    idle(3);
    step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    check("held before async reset", {31'h0, instruction_valid}, 32'h1);
    #2;
    reset = 1'b1;
    #1;
    check("async reset valid", {31'h0, instruction_valid}, 32'h0);
    check("async reset rom_enable", {31'h0, rom_enable}, 32'h0);
    check("async reset rom_address", rom_address, 32'h0);
    end_test("wrap");
    do_reset(3);
    expect_insn(32'h0, 32'h34010000);
    expect_insn(32'h4, 32'h34010001);
    check("restart bubble", {31'h0, instruction_valid}, 32'h0);
    idle(3);
    end_test("restart");

    do_reset(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
